// File: rtl/keypad_scanner.sv
// 4x4 keypad matrix scanner: walks an active-low column strobe, synchronizes the rows and
// emits one debounced key code per press/release pair.
module keypad_scanner #(
  parameter int SCAN_DIV     = 2000,
  parameter int DEBOUNCE_CNT = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  localparam logic [15:0] DWELL_LAST = 16'(SCAN_DIV - 1);
  localparam logic [15:0] DEB_LAST   = 16'(DEBOUNCE_CNT - 1);

  state_e      state_q, state_d;
  logic [3:0]  sync1_q, row_s_q;
  logic [1:0]  col_idx_q, col_idx_d;
  logic [1:0]  row_idx_q, row_idx_d;
  logic [15:0] dwell_q, dwell_d;
  logic [15:0] deb_cnt_q, deb_cnt_d;
  logic [3:0]  key_code_q, key_code_d;
  logic        key_valid_q, key_valid_d;
  logic        key_down_q, key_down_d;

  logic [1:0]  first_low;
  logic        row_high;

  // Idle rows read high, so the synchronizer resets to "no key" rather than zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 4'b1111;
      row_s_q <= 4'b1111;
    end else begin
      sync1_q <= row_in;
      row_s_q <= sync1_q;
    end
  end

  always_comb begin
    if (!row_s_q[0])      first_low = 2'd0;
    else if (!row_s_q[1]) first_low = 2'd1;
    else if (!row_s_q[2]) first_low = 2'd2;
    else                  first_low = 2'd3;
  end

  assign row_high = row_s_q[row_idx_q];

  // NOTE: every variable assigned in this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    row_idx_d   = row_idx_q;
    dwell_d     = dwell_q;
    deb_cnt_d   = deb_cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_down_d  = key_down_q;

    case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (row_s_q == 4'b1111) begin
            col_idx_d = col_idx_q + 2'd1;
          end else begin
            row_idx_d = first_low;
            deb_cnt_d = '0;
            state_d   = DEBOUNCE;
          end
        end else begin
          dwell_d = dwell_q + 16'd1;
        end
      end

      DEBOUNCE: begin
        if (!row_high) begin
          if (deb_cnt_q == DEB_LAST) begin
            key_code_d  = {row_idx_q, col_idx_q};
            key_valid_d = 1'b1;
            key_down_d  = 1'b1;
            state_d     = HELD;
          end else begin
            deb_cnt_d = deb_cnt_q + 16'd1;
          end
        end else begin
          // A bounce during press debounce is dropped silently; move on to the next column.
          col_idx_d = col_idx_q + 2'd1;
          dwell_d   = '0;
          state_d   = SCAN;
        end
      end

      HELD: begin
        if (row_high) begin
          deb_cnt_d = '0;
          state_d   = RELEASE;
        end
      end

      RELEASE: begin
        if (row_high) begin
          if (deb_cnt_q == DEB_LAST) begin
            key_down_d = 1'b0;
            col_idx_d  = col_idx_q + 2'd1;
            dwell_d    = '0;
            state_d    = SCAN;
          end else begin
            deb_cnt_d = deb_cnt_q + 16'd1;
          end
        end else begin
          deb_cnt_d = '0;
        end
      end

      default: begin
        state_d = SCAN;
        dwell_d = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SCAN;
      col_idx_q   <= '0;
      row_idx_q   <= '0;
      dwell_q     <= '0;
      deb_cnt_q   <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      dwell_q     <= dwell_d;
      deb_cnt_q   <= deb_cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
    end
  end

  assign col_out   = ~(4'b0001 << col_idx_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;

endmodule
